// File: rtl/offnariscv_pkg.sv
// Shared types for the offnariscv pipeline: stage payloads, unit commands and
// the execute-stage sequencer state encodings.
package offnariscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_cmd_e;

  typedef enum logic [2:0] {
    BRU_JAL, BRU_JALR, BRU_BEQ, BRU_BNE, BRU_BLT, BRU_BGE, BRU_BLTU, BRU_BGEU
  } bru_cmd_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            int_exc_valid;
    logic [3:0]      int_exc_cause;
  } if_data_t;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
  } operands_t;

  typedef struct packed {
    if_data_t        if_data;
    operands_t       operands;
    logic [XLEN-1:0] immediate;
    logic            alu_cmd_vld;
    alu_cmd_e        alu_cmd;
    logic            bru_cmd_vld;
    bru_cmd_e        bru_cmd;
    logic [4:0]      rd;
  } rfex_tdata_t;

  typedef struct packed {
    operands_t operands;
    alu_cmd_e  cmd;
  } rfalu_tdata_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
  } aluwb_tdata_t;

  typedef struct packed {
    operands_t       operands;
    logic [XLEN-1:0] offset;
    logic [XLEN-1:0] this_pc;
    bru_cmd_e        cmd;
  } rfbru_tdata_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            taken;
    logic [XLEN-1:0] new_pc;
  } bruwb_tdata_t;

  typedef struct packed {
    rfex_tdata_t rf_data;
  } exwb_tdata_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} ex_state_e;
  typedef enum logic [1:0] {UNIT_NONE, UNIT_ALU, UNIT_BRU} ex_unit_e;

endpackage

// File: rtl/offnariscv_ex_sequencer.sv
// Execute-stage sequencer: holds one RF beat, dispatches it to the ALU or BRU,
// collects the result and forwards it to WB, pulsing a redirect on taken branches.
module offnariscv_ex_sequencer
  import offnariscv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rfex_tvalid,
  output logic                rfex_tready,
  input  rfex_tdata_t         rfex_tdata,
  output logic                rfalu_tvalid,
  input  logic                rfalu_tready,
  output rfalu_tdata_t        rfalu_tdata,
  input  logic                aluwb_tvalid,
  output logic                aluwb_tready,
  input  aluwb_tdata_t        aluwb_tdata,
  output logic                rfbru_tvalid,
  input  logic                rfbru_tready,
  output rfbru_tdata_t        rfbru_tdata,
  input  logic                bruwb_tvalid,
  output logic                bruwb_tready,
  input  bruwb_tdata_t        bruwb_tdata,
  output logic                exwb_tvalid,
  input  logic                exwb_tready,
  output exwb_tdata_t         exwb_tdata,
  output logic [XLEN-1:0]     exwb_result,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc,
  output logic                busy
);

  ex_state_e       state_q, state_d;
  ex_unit_e        unit_sel;
  logic            redirect_q;

  // Held beat, selected unit and captured result; qualified by state only
  rfex_tdata_t     beat_p0;
  ex_unit_e        unit_p0;
  logic [XLEN-1:0] result_p0;
  logic [XLEN-1:0] redirect_pc_p0;

  logic rfex_xfer, alu_req_xfer, bru_req_xfer, alu_rsp_xfer, bru_rsp_xfer, exwb_xfer;

  assign rfex_tready  = (state_q == ST_IDLE);
  assign rfalu_tvalid = (state_q == ST_ISSUE) && (unit_p0 == UNIT_ALU);
  assign rfbru_tvalid = (state_q == ST_ISSUE) && (unit_p0 == UNIT_BRU);
  assign aluwb_tready = (state_q == ST_WAIT)  && (unit_p0 == UNIT_ALU);
  assign bruwb_tready = (state_q == ST_WAIT)  && (unit_p0 == UNIT_BRU);
  assign exwb_tvalid  = (state_q == ST_RESP);
  assign busy         = (state_q != ST_IDLE);

  assign rfex_xfer    = rfex_tvalid  && rfex_tready;
  assign alu_req_xfer = rfalu_tvalid && rfalu_tready;
  assign bru_req_xfer = rfbru_tvalid && rfbru_tready;
  assign alu_rsp_xfer = aluwb_tvalid && aluwb_tready;
  assign bru_rsp_xfer = bruwb_tvalid && bruwb_tready;
  assign exwb_xfer    = exwb_tvalid  && exwb_tready;

  // Payloads are masked by their valid so undriven held data never leaks out
  assign rfalu_tdata = rfalu_tvalid ? '{operands: beat_p0.operands, cmd: beat_p0.alu_cmd}
                                    : '0;
  assign rfbru_tdata = rfbru_tvalid ? '{operands: beat_p0.operands,
                                        offset:   beat_p0.immediate,
                                        this_pc:  beat_p0.if_data.pc,
                                        cmd:      beat_p0.bru_cmd}
                                    : '0;
  assign exwb_tdata     = exwb_tvalid ? '{rf_data: beat_p0} : '0;
  assign exwb_result    = exwb_tvalid ? result_p0 : '0;
  assign redirect_valid = redirect_q;
  assign redirect_pc    = redirect_q ? redirect_pc_p0 : '0;

  always_comb begin
    state_d  = state_q;
    unit_sel = UNIT_NONE;
    if (rfex_tdata.if_data.int_exc_valid) unit_sel = UNIT_NONE;
    else if (rfex_tdata.bru_cmd_vld)      unit_sel = UNIT_BRU;
    else if (rfex_tdata.alu_cmd_vld)      unit_sel = UNIT_ALU;
    case (state_q)
      ST_IDLE:  if (rfex_xfer) state_d = (unit_sel == UNIT_NONE) ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (alu_req_xfer || bru_req_xfer) state_d = ST_WAIT;
      ST_WAIT:  if (alu_rsp_xfer || bru_rsp_xfer) state_d = ST_RESP;
      ST_RESP:  if (exwb_xfer) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      redirect_q <= bru_rsp_xfer && bruwb_tdata.taken;
    end
  end

  // Stage p0: capture on accept, then overwrite the result on the unit response
  always_ff @(posedge clk) begin
    if (rfex_xfer) begin
      beat_p0   <= rfex_tdata;
      unit_p0   <= unit_sel;
      result_p0 <= '0;
    end
    if (alu_rsp_xfer) result_p0 <= aluwb_tdata.result;
    if (bru_rsp_xfer) begin
      result_p0      <= bruwb_tdata.result;
      redirect_pc_p0 <= bruwb_tdata.new_pc;
    end
  end

endmodule

// File: tb/tb_offnariscv_ex_sequencer.sv
// Directed bench for the execute-stage sequencer: ALU, branch, JAL, exception
// bypass, backpressure and mid-flight reset scenarios.
module tb_offnariscv_ex_sequencer;
  import offnariscv_pkg::*;

  logic         clk, rst;
  logic         rfex_tvalid, rfex_tready;
  rfex_tdata_t  rfex_tdata;
  logic         rfalu_tvalid, rfalu_tready;
  rfalu_tdata_t rfalu_tdata;
  logic         aluwb_tvalid, aluwb_tready;
  aluwb_tdata_t aluwb_tdata;
  logic         rfbru_tvalid, rfbru_tready;
  rfbru_tdata_t rfbru_tdata;
  logic         bruwb_tvalid, bruwb_tready;
  bruwb_tdata_t bruwb_tdata;
  logic         exwb_tvalid, exwb_tready;
  exwb_tdata_t  exwb_tdata;
  logic [XLEN-1:0] exwb_result, redirect_pc;
  logic         redirect_valid, busy;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  int base;

  rfex_tdata_t  b_add, b_beq, b_jal, b_exc, b_sub;
  rfalu_tdata_t exp_alu;
  rfbru_tdata_t exp_bru;

  offnariscv_ex_sequencer dut (
    .clk(clk), .rst(rst),
    .rfex_tvalid(rfex_tvalid), .rfex_tready(rfex_tready), .rfex_tdata(rfex_tdata),
    .rfalu_tvalid(rfalu_tvalid), .rfalu_tready(rfalu_tready), .rfalu_tdata(rfalu_tdata),
    .aluwb_tvalid(aluwb_tvalid), .aluwb_tready(aluwb_tready), .aluwb_tdata(aluwb_tdata),
    .rfbru_tvalid(rfbru_tvalid), .rfbru_tready(rfbru_tready), .rfbru_tdata(rfbru_tdata),
    .bruwb_tvalid(bruwb_tvalid), .bruwb_tready(bruwb_tready), .bruwb_tdata(bruwb_tdata),
    .exwb_tvalid(exwb_tvalid), .exwb_tready(exwb_tready), .exwb_tdata(exwb_tdata),
    .exwb_result(exwb_result), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (exwb_tvalid && exwb_tready) xfers++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rfex_tdata_t mk_beat(input logic [31:0] pc, input logic exc,
                                          input logic [31:0] op1, input logic [31:0] op2,
                                          input logic [31:0] imm, input logic alu_vld,
                                          input alu_cmd_e acmd, input logic bru_vld,
                                          input bru_cmd_e bcmd, input logic [4:0] rd);
    rfex_tdata_t b;
    b.if_data.pc            = pc;
    b.if_data.int_exc_valid = exc;
    b.if_data.int_exc_cause = exc ? 4'd2 : 4'd0;
    b.operands.op1          = op1;
    b.operands.op2          = op2;
    b.immediate             = imm;
    b.alu_cmd_vld           = alu_vld;
    b.alu_cmd               = acmd;
    b.bru_cmd_vld           = bru_vld;
    b.bru_cmd               = bcmd;
    b.rd                    = rd;
    return b;
  endfunction

  initial begin
    b_add = mk_beat(32'h40, 1'b0, 32'd5, 32'd7, 32'd0, 1'b1, ALU_ADD, 1'b0, BRU_JAL, 5'd3);
    b_beq = mk_beat(32'h100, 1'b0, 32'd3, 32'd3, 32'h20, 1'b0, ALU_ADD, 1'b1, BRU_BEQ, 5'd0);
    b_jal = mk_beat(32'h100, 1'b0, 32'd0, 32'd0, 32'h100, 1'b1, ALU_ADD, 1'b1, BRU_JAL, 5'd1);
    b_exc = mk_beat(32'h80, 1'b1, 32'd1, 32'd2, 32'd0, 1'b1, ALU_XOR, 1'b0, BRU_JAL, 5'd4);
    b_sub = mk_beat(32'h200, 1'b0, 32'd100, 32'd1, 32'd0, 1'b1, ALU_SUB, 1'b0, BRU_JAL, 5'd5);

    rst = 1'b1; rfex_tvalid = 1'b0; rfex_tdata = '0;
    rfalu_tready = 1'b1; aluwb_tvalid = 1'b0; aluwb_tdata = '0;
    rfbru_tready = 1'b1; bruwb_tvalid = 1'b0; bruwb_tdata = '0;
    exwb_tready = 1'b1;
    tick(); tick();
    chk("rst_rfex_tready", 256'(rfex_tready), 256'(1'b1));
    chk("rst_busy", 256'(busy), 256'(1'b0));
    chk("rst_valids", 256'({rfalu_tvalid, rfbru_tvalid, exwb_tvalid, redirect_valid}), 256'(4'b0));
    chk("rst_readys", 256'({aluwb_tready, bruwb_tready}), 256'(2'b0));
    chk("rst_result", 256'(exwb_result), 256'(32'd0));
    rst = 1'b0;
    tick();

    // ADD 5+7
    rfex_tdata = b_add; rfex_tvalid = 1'b1;
    tick();
    rfex_tvalid = 1'b0;
    exp_alu.operands.op1 = 32'd5; exp_alu.operands.op2 = 32'd7; exp_alu.cmd = ALU_ADD;
    chk("add_c1_rfalu_tvalid", 256'(rfalu_tvalid), 256'(1'b1));
    chk("add_c1_rfalu_tdata", 256'(rfalu_tdata), 256'(exp_alu));
    chk("add_c1_rfbru_tvalid", 256'(rfbru_tvalid), 256'(1'b0));
    chk("add_c1_rfex_tready", 256'(rfex_tready), 256'(1'b0));
    chk("add_c1_aluwb_tready", 256'(aluwb_tready), 256'(1'b0));
    aluwb_tvalid = 1'b1; aluwb_tdata.result = 32'd12;
    tick();
    chk("add_c2_aluwb_tready", 256'(aluwb_tready), 256'(1'b1));
    chk("add_c2_bruwb_tready", 256'(bruwb_tready), 256'(1'b0));
    tick();
    aluwb_tvalid = 1'b0;
    chk("add_c3_exwb_tvalid", 256'(exwb_tvalid), 256'(1'b1));
    chk("add_c3_exwb_result", 256'(exwb_result), 256'(32'd12));
    chk("add_c3_rf_data", 256'(exwb_tdata.rf_data), 256'(b_add));
    chk("add_c3_redirect", 256'(redirect_valid), 256'(1'b0));
    tick();
    chk("add_done_busy", 256'(busy), 256'(1'b0));
    chk("add_done_exwb_tvalid", 256'(exwb_tvalid), 256'(1'b0));

    // BEQ taken with exwb backpressure on the first RESP cycle
    rfex_tdata = b_beq; rfex_tvalid = 1'b1;
    tick();
    rfex_tvalid = 1'b0;
    exp_bru.operands.op1 = 32'd3; exp_bru.operands.op2 = 32'd3;
    exp_bru.offset = 32'h20; exp_bru.this_pc = 32'h100; exp_bru.cmd = BRU_BEQ;
    chk("beq_rfbru_tvalid", 256'(rfbru_tvalid), 256'(1'b1));
    chk("beq_rfbru_tdata", 256'(rfbru_tdata), 256'(exp_bru));
    chk("beq_rfalu_tvalid", 256'(rfalu_tvalid), 256'(1'b0));
    bruwb_tvalid = 1'b1; bruwb_tdata.result = 32'd0; bruwb_tdata.taken = 1'b1;
    bruwb_tdata.new_pc = 32'h120;
    tick();
    chk("beq_bruwb_tready", 256'(bruwb_tready), 256'(1'b1));
    chk("beq_aluwb_tready", 256'(aluwb_tready), 256'(1'b0));
    exwb_tready = 1'b0;
    tick();
    bruwb_tvalid = 1'b0;
    chk("beq_redirect_valid", 256'(redirect_valid), 256'(1'b1));
    chk("beq_redirect_pc", 256'(redirect_pc), 256'(32'h120));
    chk("beq_exwb_tvalid", 256'(exwb_tvalid), 256'(1'b1));
    tick();
    chk("beq_redirect_once", 256'(redirect_valid), 256'(1'b0));
    chk("beq_exwb_held", 256'(exwb_tvalid), 256'(1'b1));
    chk("beq_rf_data", 256'(exwb_tdata.rf_data), 256'(b_beq));
    exwb_tready = 1'b1;
    tick();
    chk("beq_done_busy", 256'(busy), 256'(1'b0));

    // JAL with both command valids: BRU wins
    rfex_tdata = b_jal; rfex_tvalid = 1'b1;
    tick();
    rfex_tvalid = 1'b0;
    chk("jal_rfalu_tvalid", 256'(rfalu_tvalid), 256'(1'b0));
    chk("jal_rfbru_tvalid", 256'(rfbru_tvalid), 256'(1'b1));
    chk("jal_rfbru_cmd", 256'(rfbru_tdata.cmd), 256'(BRU_JAL));
    bruwb_tvalid = 1'b1; bruwb_tdata.result = 32'h104; bruwb_tdata.taken = 1'b1;
    bruwb_tdata.new_pc = 32'h200;
    tick();
    tick();
    bruwb_tvalid = 1'b0;
    chk("jal_exwb_result", 256'(exwb_result), 256'(32'h104));
    chk("jal_redirect_pc", 256'(redirect_pc), 256'(32'h200));
    tick();

    // Exception bypass: exwb one cycle after accept, result 0
    rfex_tdata = b_exc; rfex_tvalid = 1'b1;
    tick();
    rfex_tvalid = 1'b0;
    chk("exc_no_request", 256'({rfalu_tvalid, rfbru_tvalid}), 256'(2'b0));
    chk("exc_exwb_tvalid", 256'(exwb_tvalid), 256'(1'b1));
    chk("exc_exwb_result", 256'(exwb_result), 256'(32'd0));
    chk("exc_redirect", 256'(redirect_valid), 256'(1'b0));
    tick();

    // Backpressure on the ALU request, then on exwb
    rfex_tdata = b_sub; rfex_tvalid = 1'b1; rfalu_tready = 1'b0;
    tick();
    rfex_tvalid = 1'b0;
    exp_alu.operands.op1 = 32'd100; exp_alu.operands.op2 = 32'd1; exp_alu.cmd = ALU_SUB;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rfalu_tvalid", 256'(rfalu_tvalid), 256'(1'b1));
      chk("bp_rfalu_tdata", 256'(rfalu_tdata), 256'(exp_alu));
      chk("bp_rfex_tready", 256'(rfex_tready), 256'(1'b0));
      tick();
    end
    rfalu_tready = 1'b1; aluwb_tvalid = 1'b1; aluwb_tdata.result = 32'd99;
    tick();
    chk("bp_wait_aluwb_tready", 256'(aluwb_tready), 256'(1'b1));
    exwb_tready = 1'b0;
    tick();
    aluwb_tvalid = 1'b0;
    base = xfers;
    for (int i = 0; i < 2; i++) begin
      chk("bp_exwb_tvalid", 256'(exwb_tvalid), 256'(1'b1));
      chk("bp_exwb_result", 256'(exwb_result), 256'(32'd99));
      chk("bp_resp_rfex_tready", 256'(rfex_tready), 256'(1'b0));
      tick();
    end
    exwb_tready = 1'b1;
    rfex_tdata = b_exc; rfex_tvalid = 1'b1;
    chk("bp_last_rfex_tready", 256'(rfex_tready), 256'(1'b0));
    tick();
    chk("bp_one_transfer", 256'(xfers - base), 256'(1));
    chk("bp_not_accepted_busy", 256'(busy), 256'(1'b0));
    chk("bp_idle_rfex_tready", 256'(rfex_tready), 256'(1'b1));
    tick();
    rfex_tvalid = 1'b0;
    chk("bp_next_exwb_tvalid", 256'(exwb_tvalid), 256'(1'b1));
    chk("bp_next_rf_data", 256'(exwb_tdata.rf_data), 256'(b_exc));
    tick();

    // Reset while waiting on the ALU; a stale result must be ignored
    rfex_tdata = b_add; rfex_tvalid = 1'b1;
    tick();
    rfex_tvalid = 1'b0;
    tick();
    chk("rstw_in_wait", 256'(aluwb_tready), 256'(1'b1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_valids", 256'({rfalu_tvalid, rfbru_tvalid, exwb_tvalid, redirect_valid}), 256'(4'b0));
    chk("rstw_busy", 256'(busy), 256'(1'b0));
    aluwb_tvalid = 1'b1; aluwb_tdata.result = 32'd77;
    chk("rstw_stale_tready", 256'(aluwb_tready), 256'(1'b0));
    tick();
    chk("rstw_stale_busy", 256'(busy), 256'(1'b0));
    chk("rstw_stale_exwb", 256'(exwb_tvalid), 256'(1'b0));
    aluwb_tvalid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/offnariscv_ex_sequencer.md
# offnariscv_ex_sequencer

Execute-stage controller sitting between the RF stage and the WB stage of the offnariscv pipeline. It accepts one `rfex_tdata_t` beat at a time and dispatches it to the ALU or the BRU. It collects that unit's result and emits an `exwb_tdata_t` beat plus the result word. On a taken branch it raises a one-cycle redirect/flush toward the front end.

## Interface
Parameters:
- `XLEN`, 32 (from `offnariscv_pkg`): datapath width; not overridable per instance.

Ports:
- `clk`  in  1  core clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `rfex_tvalid` / `rfex_tready` / `rfex_tdata`  in/out/in  1/1/`rfex_tdata_t`  upstream instruction stream.
- `rfalu_tvalid` / `rfalu_tready` / `rfalu_tdata`  out/in/out  1/1/`rfalu_tdata_t`  ALU request.
- `aluwb_tvalid` / `aluwb_tready` / `aluwb_tdata`  in/out/in  1/1/`aluwb_tdata_t`  ALU result.
- `rfbru_tvalid` / `rfbru_tready` / `rfbru_tdata`  out/in/out  1/1/`rfbru_tdata_t`  BRU request.
- `bruwb_tvalid` / `bruwb_tready` / `bruwb_tdata`  in/out/in  1/1/`bruwb_tdata_t`  BRU result.
- `exwb_tvalid` / `exwb_tready` / `exwb_tdata`  out/in/out  1/1/`exwb_tdata_t`  downstream stream.
- `exwb_result`  out  `XLEN`  rd write value; qualified by `exwb_tvalid`.
- `redirect_valid`  out  1  one-cycle pulse when a taken branch resolves.
- `redirect_pc`  out  `XLEN`  target PC; qualified by `redirect_valid`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- All handshakes are AXI-Stream style. A transfer occurs on a cycle with valid && ready. Once a valid is asserted it stays high, with its data stable, until the transfer.
- The state machine has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `rfex_tready`=1. On a transfer the beat is captured into a held register.
  - Unit select:
    - `if_data.int_exc_valid`=1 → bypass.
    - Else `bru_cmd_vld`=1 → BRU. This takes priority, so JAL/JALR results come from the BRU.
    - Else `alu_cmd_vld`=1 → ALU.
    - Else → bypass.
  - Bypass goes straight to RESP with result 0. Any other selection goes to ISSUE.
- ISSUE:
  - The selected unit's tvalid=1.
  - ALU payload: `operands`=held operands, `cmd`=held `alu_cmd`.
  - BRU payload: `operands`=held operands, `offset`=held `immediate`, `this_pc`=held `if_data.pc`, `cmd`=held `bru_cmd`.
  - The transfer moves the state to WAIT.
  - The unselected unit's tvalid stays 0.
- WAIT:
  - Only the selected unit's result tready=1; the other result tready=0.
  - The transfer captures `result` and moves the state to RESP.
  - On the BRU transfer with `taken`=1: `redirect_valid`=1 in the next cycle, `redirect_pc`=captured `new_pc`.
- RESP:
  - `exwb_tvalid`=1, `exwb_tdata.rf_data`=held beat, `exwb_result`=captured result.
  - The transfer moves the state to IDLE.
  - A new `rfex` beat is not accepted in that same cycle.
- Redirect rule: the instruction that produced the redirect still completes to exwb; it is not flushed. Younger instructions are killed upstream, which is outside this block.
- Unexpected result traffic: results arriving while the block is not in WAIT for that unit are not accepted, because tready=0.

## Timing
- Reset values: state IDLE; `rfex_tready`=1, since it depends only on the state; all other outputs 0.
- `rst` asserted mid-operation drops every valid in the next cycle. Held data is discarded, and any in-flight unit result is ignored because its tready=0.
- With zero-wait units, the minimum per-instruction occupancy (rfex accept cycle to exwb transfer) is:
  - ALU/BRU: 4 cycles. Accept at c0, request at c1, result at c2 (combinational unit), exwb at c3.
  - Bypass: 2 cycles. Accept at c0, exwb at c1.
- Each unit-side stall adds one cycle per stalled cycle.
- `redirect_valid` is high for exactly one cycle, the cycle the state enters RESP. If exwb backpressures, it is never repeated.
- Throughput is at most one instruction in flight.

## Structure
- Belongs in `offnariscv_pkg`: an `ex_state_e` enum (IDLE, ISSUE, WAIT, RESP) and an `ex_unit_e` enum (NONE, ALU, BRU).
- Packing `rfalu_tdata_t` and `rfbru_tdata_t` from the held beat is pure wiring inside this module.
- No sub-module.

## Test plan
- ADD, op1=5, op2=7; ALU returns 12 with rfalu/aluwb ready always high → `exwb_result`=12 on cycle c3; `rfbru_tvalid` never asserted; `redirect_valid` stays 0.
- BEQ, op1=op2=3, pc=0x100, imm=0x20; BRU returns taken=1, new_pc=0x120 → redirect pulse of 1 cycle with `redirect_pc`=0x120; exwb still emitted.
- JAL with both `alu_cmd_vld` and `bru_cmd_vld` set → only the BRU is requested; BRU result 0x104 → `exwb_result`=0x104.
- `int_exc_valid`=1 → no unit request; `exwb_tvalid` at c1 with result 0.
- Backpressure: rfalu_tready low for 3 cycles, then exwb_tready low for 2 cycles → payloads stay stable; exactly one exwb transfer; `rfex_tready` stays 0 throughout.
- `rst` asserted during WAIT → all valids are 0 the next cycle and state is IDLE; a stale aluwb beat presented afterward is not accepted.
